image_pass_sequencer: RTL and testbench

//   Runs a chain of image-processing passes (RGB->HSV, filters, blob scans) that share one SRAM port.

---
 rtl/image_pass_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_image_pass_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_pass_sequencer.sv
// ----------------------------------------------------------------------------
// image_pass_sequencer
//
// Runs a chain of image-processing passes that share one SRAM port. The
// passes selected by pass_mask_i are enabled one at a time in index order
// using the enable/done handshake. The active pass's write strobe, address
// and data are routed onto the memory port.
//
// Ports
//   clk_i               system clock
//   reset_i             synchronous, active-high reset
//   start_i             level enable for the whole chain
//   pass_mask_i         bit i set -> run pass i (sampled when the chain starts)
//   mem_pause_i         memory stall; copied to every pass, freezes watchdog
//   busy_o              chain in progress (SELECT / RUN / RELEASE)
//   all_done_o          chain finished; held until start_i falls
//   timeout_err_o       a pass exceeded TimeoutCycles; cleared on next start
//   current_pass_o      index of the pass being run or released
//   pass_enable_o       one-hot enable to the passes
//   pass_pause_o        mem_pause_i copied to every slot
//   pass_done_i         done flags from the passes
//   pass_wren_i         per-pass write strobes
//   pass_address_i      per-pass addresses, slot i at [18*i+17:18*i]
//   pass_data_write_i   per-pass write data, slot i at [32*i+31:32*i]
//   mem_wren_o          write strobe to the SRAM port
//   mem_address_o       address to the SRAM port
//   mem_data_write_o    write data to the SRAM port
// ----------------------------------------------------------------------------
module image_pass_sequencer #(
    parameter int NumPasses     = 4,
    parameter int IndexWidth    = 2,
    parameter int TimeoutCycles = 2000000
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic [NumPasses-1:0]      pass_mask_i,
    input  logic                      mem_pause_i,
    output logic                      busy_o,
    output logic                      all_done_o,
    output logic                      timeout_err_o,
    output logic [IndexWidth-1:0]     current_pass_o,
    output logic [NumPasses-1:0]      pass_enable_o,
    output logic [NumPasses-1:0]      pass_pause_o,
    input  logic [NumPasses-1:0]      pass_done_i,
    input  logic [NumPasses-1:0]      pass_wren_i,
    input  logic [NumPasses*18-1:0]   pass_address_i,
    input  logic [NumPasses*32-1:0]   pass_data_write_i,
    output logic                      mem_wren_o,
    output logic [17:0]               mem_address_o,
    output logic [31:0]               mem_data_write_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_RUN,
        ST_RELEASE,
        ST_FINISH
    } state_e;

    // The search index is one bit wider than the pass index so that
    // "one past the last pass" (NumPasses) is representable and simply
    // yields no candidate in SELECT.
    localparam int             IdxW     = IndexWidth + 1;
    localparam logic [31:0]    WdogLast = 32'(TimeoutCycles - 1);

    state_e                  state_q, state_d;
    logic [NumPasses-1:0]    mask_q, mask_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [IndexWidth-1:0]   cur_q, cur_d;
    logic [31:0]             wdog_q, wdog_d;
    logic                    timeout_q, timeout_d;
    logic [NumPasses-1:0]    enable_q, enable_d;

    // Per-slot views of the packed pass buses.
    logic [17:0]             addr_arr [NumPasses];
    logic [31:0]             data_arr [NumPasses];
    logic [NumPasses-1:0]    cand;

    genvar gi;
    generate
        for (gi = 0; gi < NumPasses; gi++) begin : g_slot
            assign addr_arr[gi] = pass_address_i[18*gi +: 18];
            assign data_arr[gi] = pass_data_write_i[32*gi +: 32];
            assign cand[gi]     = mask_q[gi] && (IdxW'(gi) >= idx_q);
        end
    endgenerate

    // Lowest selected slot at or above idx_q.
    logic                    found;
    logic [IndexWidth-1:0]   found_idx;

    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        for (int i = NumPasses - 1; i >= 0; i--) begin
            if (cand[i]) begin
                found     = 1'b1;
                found_idx = IndexWidth'(i);
            end
        end
    end

    logic sel_done;
    assign sel_done = pass_done_i[cur_q];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            mask_q    <= '0;
            idx_q     <= '0;
            cur_q     <= '0;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
            enable_q  <= '0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            idx_q     <= idx_d;
            cur_q     <= cur_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
            enable_q  <= enable_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Priority inside RUN: start low, then done,
    // then watchdog expiry.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        idx_d     = idx_q;
        cur_d     = cur_q;
        wdog_d    = wdog_q;
        timeout_d = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    mask_d    = pass_mask_i;
                    timeout_d = 1'b0;
                    idx_d     = '0;
                    state_d   = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (!start_i) begin
                    state_d = ST_IDLE;
                end else if (found) begin
                    cur_d   = found_idx;
                    wdog_d  = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_FINISH;
                end
            end
            ST_RUN: begin
                if (!start_i) begin
                    state_d = ST_IDLE;
                end else if (sel_done) begin
                    state_d = ST_RELEASE;
                end else if (!mem_pause_i) begin
                    if (wdog_q == WdogLast) begin
                        timeout_d = 1'b1;
                        state_d   = ST_FINISH;
                    end else begin
                        wdog_d = wdog_q + 32'd1;
                    end
                end
            end
            ST_RELEASE: begin
                if (!start_i) begin
                    state_d = ST_IDLE;
                end else if (!sel_done) begin
                    // cur_q <= NumPasses-1, so this tops out at NumPasses.
                    idx_d   = IdxW'(cur_q) + IdxW'(1);
                    state_d = ST_SELECT;
                end
            end
            ST_FINISH: begin
                if (!start_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The enable is registered and follows the RUN state exactly, so
        // it drops on the same edge that leaves RUN for any reason.
        enable_d = '0;
        if (state_d == ST_RUN) begin
            enable_d = NumPasses'(1) << cur_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy_o           = (state_q == ST_SELECT) || (state_q == ST_RUN) ||
                           (state_q == ST_RELEASE);
        all_done_o       = (state_q == ST_FINISH);
        mem_wren_o       = 1'b0;
        mem_address_o    = '0;
        mem_data_write_o = '0;
        // Only RUN forwards; in RELEASE a pass may still hold its last strobe.
        if (state_q == ST_RUN) begin
            mem_wren_o       = pass_wren_i[cur_q];
            mem_address_o    = addr_arr[cur_q];
            mem_data_write_o = data_arr[cur_q];
        end
    end

    assign timeout_err_o  = timeout_q;
    assign current_pass_o = cur_q;
    assign pass_enable_o  = enable_q;
    assign pass_pause_o   = {NumPasses{mem_pause_i}};

endmodule

// File: tb/tb_image_pass_sequencer.sv
module tb_image_pass_sequencer;

    logic         clk;
    logic         reset;
    logic         start;
    logic [3:0]   pass_mask;
    logic         mem_pause;
    logic         busy_o;
    logic         all_done_o;
    logic         timeout_err_o;
    logic [1:0]   current_pass_o;
    logic [3:0]   pass_enable_o;
    logic [3:0]   pass_pause_o;
    logic [3:0]   pass_done;
    logic [3:0]   pass_wren;
    logic [71:0]  pass_address;
    logic [127:0] pass_data_write;
    logic         mem_wren_o;
    logic [17:0]  mem_address_o;
    logic [31:0]  mem_data_write_o;

    image_pass_sequencer #(
        .NumPasses    (4),
        .IndexWidth   (2),
        .TimeoutCycles(50)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .start_i          (start),
        .pass_mask_i      (pass_mask),
        .mem_pause_i      (mem_pause),
        .busy_o           (busy_o),
        .all_done_o       (all_done_o),
        .timeout_err_o    (timeout_err_o),
        .current_pass_o   (current_pass_o),
        .pass_enable_o    (pass_enable_o),
        .pass_pause_o     (pass_pause_o),
        .pass_done_i      (pass_done),
        .pass_wren_i      (pass_wren),
        .pass_address_i   (pass_address),
        .pass_data_write_i(pass_data_write),
        .mem_wren_o       (mem_wren_o),
        .mem_address_o    (mem_address_o),
        .mem_data_write_o (mem_data_write_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard of writes the stub passes issue while enabled.
    typedef struct packed {
        logic [17:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];
    int  n_wr;
    int  en_log[$];
    int  run_len1;

    // Stub pass controls
    int  cnt [4];
    int  hold[4];
    bit  never_done[4];
    bit  same_wr;
    bit  pause_test;

    task automatic drive_wr(input int i, input logic [17:0] a, input logic [31:0] d);
        wr_t w;
        pass_wren[i]               = 1'b1;
        pass_address[18*i +: 18]   = a;
        pass_data_write[32*i +: 32] = d;
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
    endtask

    // Stub passes: writes on their 3rd and 6th enabled cycle, done on the
    // 10th (unless never_done), done held 3 cycles after enable falls.
    initial begin
        pass_done       = '0;
        pass_wren       = '0;
        pass_address    = '0;
        pass_data_write = '0;
        mem_pause       = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cnt[i]        = 0;
            hold[i]       = 0;
            never_done[i] = 1'b0;
        end
        same_wr    = 1'b0;
        pause_test = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (pass_enable_o[i]) begin
                    cnt[i]++;
                    pass_wren[i] = 1'b0;
                    if (cnt[i] == 3 || cnt[i] == 6)
                        drive_wr(i, {2'(i), 16'(cnt[i])}, 32'hA500_0000 | 32'(i << 8) | 32'(cnt[i]));
                    if (!never_done[i] && cnt[i] >= 10) begin
                        pass_done[i] = 1'b1;
                        hold[i]      = 3;
                        if (same_wr && cnt[i] == 10)
                            drive_wr(i, 18'h12C02, 32'hDEAD_BEEF);
                    end
                end else begin
                    cnt[i] = 0;
                    if (hold[i] > 0) begin
                        hold[i]--;
                        if (!same_wr) pass_wren[i] = 1'b0;
                    end else begin
                        pass_done[i] = 1'b0;
                        pass_wren[i] = 1'b0;
                    end
                end
            end
            mem_pause = pause_test && pass_enable_o[1] && cnt[1] >= 5 && cnt[1] <= 24;
        end
    end

    // Monitor: sampled mid-cycle.
    logic [3:0] prev_en = '0;
    always @(negedge clk) begin
        chk("onehot", 64'($countones(pass_enable_o) <= 1), 64'd1);
        chk("pause_copy", 64'(pass_pause_o), 64'({4{mem_pause}}));
        if (pass_enable_o == 4'b0)
            chk("wren_when_idle", 64'(mem_wren_o), 64'd0);
        if (mem_wren_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'(mem_address_o), 64'h3FFFF_FFFF);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                n_wr++;
                $display("write addr=0x%05h data=0x%08h (expected 0x%05h/0x%08h)",
                         mem_address_o, mem_data_write_o, w.a, w.d);
                chk("wr_addr", 64'(mem_address_o), 64'(w.a));
                chk("wr_data", 64'(mem_data_write_o), 64'(w.d));
            end
        end
        for (int i = 0; i < 4; i++)
            if (pass_enable_o[i] && !prev_en[i]) en_log.push_back(i);
        if (pass_enable_o[1]) run_len1++;
        prev_en <= pass_enable_o;
    end

    task automatic new_test();
        en_log.delete();
        n_wr     = 0;
        run_len1 = 0;
    endtask

    task automatic chk_log(input string tag, input int exp_n, input int e0, input int e1);
        chk({tag, "_npass"}, 64'(en_log.size()), 64'(exp_n));
        if (exp_n > 0 && en_log.size() > 0) chk({tag, "_pass0"}, 64'(en_log[0]), 64'(e0));
        if (exp_n > 1 && en_log.size() > 1) chk({tag, "_pass1"}, 64'(en_log[1]), 64'(e1));
    endtask

    task automatic wait_all_done(input string tag, input int budget);
        int n = 0;
        while (!all_done_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_all_done"}, 64'(all_done_o), 64'd1);
        chk({tag, "_busy_off"}, 64'(busy_o), 64'd0);
    endtask

    task automatic wait_enable(input string tag, input int idx, input int budget);
        int n = 0;
        while (!pass_enable_o[idx] && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_enable_seen"}, 64'(pass_enable_o[idx]), 64'd1);
    endtask

    task automatic end_chain(input string tag);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_done_clear"}, 64'(all_done_o), 64'd0);
        chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
        $display("chain %s complete: passes=%0d writes=%0d timeout=%0d",
                 tag, en_log.size(), n_wr, timeout_err_o);
    endtask

    task automatic launch(input logic [3:0] m);
        @(posedge clk); #1;
        pass_mask = m;
        start     = 1'b1;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        pass_mask = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_enable", 64'(pass_enable_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_all_done", 64'(all_done_o), 64'd0);
        chk("rst_timeout", 64'(timeout_err_o), 64'd0);
        chk("rst_cur", 64'(current_pass_o), 64'd0);
        chk("rst_mem", 64'({mem_wren_o, mem_address_o, mem_data_write_o}), 64'd0);
        reset = 1'b0;

        // Mask 0101: pass0 then pass2, never pass1.
        new_test();
        launch(4'b0101);
        wait_all_done("t1", 200);
        chk_log("t1", 2, 0, 2);
        chk("t1_writes", 64'(n_wr), 64'd4);
        chk("t1_timeout", 64'(timeout_err_o), 64'd0);
        end_chain("t1");

        // Empty mask: FINISH two cycles after start.
        new_test();
        launch(4'b0000);
        @(posedge clk); @(negedge clk);
        chk("t2_select_busy", 64'(busy_o), 64'd1);
        chk("t2_select_done", 64'(all_done_o), 64'd0);
        @(posedge clk); @(negedge clk);
        chk("t2_finish_done", 64'(all_done_o), 64'd1);
        chk_log("t2", 0, 0, 0);
        chk("t2_writes", 64'(n_wr), 64'd0);
        end_chain("t2");

        // Done and write in the same cycle; stale strobe held in RELEASE.
        new_test();
        same_wr = 1'b1;
        launch(4'b0010);
        wait_all_done("t3", 200);
        chk_log("t3", 1, 1, 0);
        chk("t3_writes", 64'(n_wr), 64'd3);
        end_chain("t3");
        same_wr = 1'b0;

        // Watchdog: pass1 never done, 20 paused cycles.
        new_test();
        never_done[1] = 1'b1;
        pause_test    = 1'b1;
        launch(4'b1110);
        wait_all_done("t4", 300);
        chk("t4_timeout", 64'(timeout_err_o), 64'd1);
        chk("t4_run_len", 64'(run_len1), 64'd70);
        chk_log("t4", 1, 1, 0);
        chk("t4_writes", 64'(n_wr), 64'd2);
        never_done[1] = 1'b0;
        pause_test    = 1'b0;

        // Back-to-back: start low one cycle, then a new chain.
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("t6_idle_done", 64'(all_done_o), 64'd0);
        chk("t6_timeout_held", 64'(timeout_err_o), 64'd1);
        new_test();
        pass_mask = 4'b1000;
        start     = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("t6_timeout_clear", 64'(timeout_err_o), 64'd0);
        chk("t6_busy", 64'(busy_o), 64'd1);
        wait_all_done("t6", 200);
        chk_log("t6", 1, 3, 0);
        chk("t6_writes", 64'(n_wr), 64'd2);
        end_chain("t6");

        // Reset mid-RUN.
        new_test();
        launch(4'b1111);
        wait_enable("t5a", 0, 20);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("t5a_enable", 64'(pass_enable_o), 64'd0);
        chk("t5a_busy", 64'(busy_o), 64'd0);
        chk("t5a_all_done", 64'(all_done_o), 64'd0);
        chk("t5a_cur", 64'(current_pass_o), 64'd0);
        reset = 1'b0;

        // Start dropped mid-RUN.
        new_test();
        launch(4'b0100);
        wait_enable("t5b", 2, 20);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("t5b_enable", 64'(pass_enable_o), 64'd0);
        chk("t5b_busy", 64'(busy_o), 64'd0);
        chk("t5b_all_done", 64'(all_done_o), 64'd0);
        repeat (3) @(negedge clk);
        chk("t5b_stay_idle", 64'({busy_o, all_done_o}), 64'd0);
        chk("t5b_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got no end, expected end");
        $fatal(1, "global timeout");
    end

endmodule
